// File: rtl/result_buffer_pkg.sv
// Shared sizing for the result buffer, its datapath top and its bench.
package result_buffer_pkg;
  localparam int unsigned RB_DATA_W = 16;
  localparam int unsigned RB_DEPTH  = 4;
  localparam int unsigned RB_ADDR_W = 2;
  localparam int unsigned RB_DROP_W = 8;
endpackage

// File: rtl/result_buffer_if.sv
// Capture and consumer-side signals of the result buffer.
interface result_buffer_if
  import result_buffer_pkg::*;
#(
  parameter int unsigned DATA_W = RB_DATA_W,
  parameter int unsigned ADDR_W = RB_ADDR_W,
  parameter int unsigned DROP_W = RB_DROP_W
);
  logic              done;
  logic [DATA_W-1:0] result;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W:0]   count;
  logic              full;
  logic              overflow;
  logic [DROP_W-1:0] drop_cnt;

  modport slave (
    input  done, result, out_ready,
    output out_data, out_valid, count, full, overflow, drop_cnt
  );

  modport master (
    output done, result, out_ready,
    input  out_data, out_valid, count, full, overflow, drop_cnt
  );
endinterface

// File: rtl/result_buffer_rise_detect.sv
// Turns the datapath done level into a one-cycle capture pulse.
module rise_detect (
  input  logic clk,
  input  logic reset,
  input  logic done,
  output logic cap
);
  logic done_q;
  logic done_d;

  always_comb begin
    done_d = done;
    cap    = done & ~done_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) done_q <= 1'b0;
    else       done_q <= done_d;
  end
endmodule

// File: rtl/result_buffer.sv
// Result FIFO: captures on done rising edge, first-word fall-through read side,
// sticky overflow flag and saturating drop counter.
module result_buffer
  import result_buffer_pkg::*;
#(
  parameter int unsigned DATA_W = RB_DATA_W,
  parameter int unsigned DEPTH  = RB_DEPTH,
  parameter int unsigned ADDR_W = RB_ADDR_W,
  parameter int unsigned DROP_W = RB_DROP_W
) (
  input  logic            clk,
  input  logic            reset,
  result_buffer_if.slave  bus
);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
  localparam logic [DROP_W-1:0] DROP_ONE = DROP_W'(1);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              overflow_q, overflow_d;
  logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;

  logic cap, pop, wr_en, drop, full, out_valid;

  rise_detect u_rise_detect (
    .clk   (clk),
    .reset (reset),
    .done  (bus.done),
    .cap   (cap)
  );

  always_comb begin
    out_valid  = (count_q != '0);
    full       = (count_q == CNT_FULL);
    pop        = out_valid & bus.out_ready;
    // A pop on a full FIFO frees the slot the same edge, so the capture is kept.
    wr_en      = cap & (~full | pop);
    drop       = cap & full & ~pop;

    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;

    if (wr_en) begin
      mem_d[wr_ptr_q] = bus.result;
      wr_ptr_d        = wr_ptr_q + PTR_ONE;
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_ONE;

    case ({wr_en, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    if (drop) begin
      overflow_d = 1'b1;
      if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + DROP_ONE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_q      <= '{default: '0};
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign bus.out_data  = mem_q[rd_ptr_q];
  assign bus.out_valid = out_valid;
  assign bus.count     = count_q;
  assign bus.full      = full;
  assign bus.overflow  = overflow_q;
  assign bus.drop_cnt  = drop_cnt_q;
endmodule

// File: tb/tb_result_buffer.sv
// Scoreboard bench for result_buffer: expected entries queued on capture, checked on pop.
module tb_result_buffer;
  import result_buffer_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  result_buffer_if bus ();

  result_buffer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [15:0] sb[$];
  logic        m_done_q;
  logic        m_ovf;
  int unsigned m_drop;
  int unsigned n_cmp;
  int unsigned n_err;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_state();
    check_eq("out_valid", 32'(bus.out_valid), 32'(sb.size() != 0));
    check_eq("count",     32'(bus.count),     32'(sb.size()));
    check_eq("full",      32'(bus.full),      32'(sb.size() == RB_DEPTH));
    check_eq("overflow",  32'(bus.overflow),  32'(m_ovf));
    check_eq("drop_cnt",  32'(bus.drop_cnt),  32'(m_drop));
  endtask

  // One clock: called between edges, checks settled outputs, drives inputs,
  // advances the model across the coming rising edge.
  task automatic cycle(input logic d, input logic [15:0] r, input logic rdy);
    logic cap, pop;
    check_state();
    bus.done      = d;
    bus.result    = r;
    bus.out_ready = rdy;
    cap = d & ~m_done_q;
    pop = (sb.size() != 0) & rdy;
    if (pop) check_eq("out_data", 32'(bus.out_data), 32'(sb.pop_front()));
    if (cap) begin
      if (sb.size() < RB_DEPTH) sb.push_back(r);
      else begin
        m_ovf = 1'b1;
        if (m_drop < 255) m_drop++;
      end
    end
    m_done_q = d;
    @(negedge clk);
  endtask

  task automatic pulse(input logic [15:0] r);
    cycle(1'b1, r, 1'b0);
    cycle(1'b0, r, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < 6; i++) cycle(1'b0, 16'h0, 1'b1);
  endtask

  // Reset asserted between edges; outputs must clear without a clock edge.
  task automatic async_reset(input logic hold_done);
    #1 reset = 1'b1;
    bus.done = hold_done;
    #1;
    check_eq("rst_out_valid", 32'(bus.out_valid), 32'(0));
    check_eq("rst_count",     32'(bus.count),     32'(0));
    check_eq("rst_overflow",  32'(bus.overflow),  32'(0));
    check_eq("rst_drop_cnt",  32'(bus.drop_cnt),  32'(0));
    check_eq("rst_full",      32'(bus.full),      32'(0));
    sb.delete();
    m_done_q = 1'b0;
    m_ovf    = 1'b0;
    m_drop   = 0;
    @(negedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    m_done_q = 1'b0; m_ovf = 1'b0; m_drop = 0;
    reset = 1'b1;
    bus.done = 1'b0; bus.result = '0; bus.out_ready = 1'b0;
    @(negedge clk);
    check_state();
    #1 reset = 1'b0;

    // 1: long done level yields exactly one capture
    for (int i = 0; i < 5; i++) cycle(1'b1, 16'h0042, 1'b0);
    cycle(1'b0, 16'h0042, 1'b0);
    check_eq("t1_count", 32'(bus.count), 32'(1));
    check_eq("t1_data",  32'(bus.out_data), 32'h42);
    drain();

    // 2: fill to full, then drain in order
    for (int i = 1; i <= 4; i++) pulse(16'(i));
    check_eq("t2_full", 32'(bus.full), 32'(1));
    drain();

    // 3: overflow, then drop counter saturation
    for (int i = 1; i <= 4; i++) pulse(16'(i));
    pulse(16'h00FF);
    check_eq("t3_overflow", 32'(bus.overflow), 32'(1));
    check_eq("t3_drop1",    32'(bus.drop_cnt), 32'(1));
    for (int i = 0; i < 300; i++) pulse(16'(i + 16'h200));
    check_eq("t3_drop_sat", 32'(bus.drop_cnt), 32'd255);
    drain();

    // 4: capture and pop on the same edge while full
    async_reset(1'b0);
    for (int i = 1; i <= 4; i++) pulse(16'(i));
    cycle(1'b1, 16'h0005, 1'b1);
    cycle(1'b0, 16'h0005, 1'b0);
    check_eq("t4_count",    32'(bus.count), 32'(4));
    check_eq("t4_overflow", 32'(bus.overflow), 32'(0));
    drain();

    // 5: async reset with entries held, done high across release
    pulse(16'h0011);
    pulse(16'h0022);
    async_reset(1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b1, 16'h0077, 1'b0);
    check_eq("t5_count", 32'(bus.count), 32'(1));
    cycle(1'b0, 16'h0077, 1'b0);
    drain();

    // 6: interleaved writes and reads across pointer wrap, incl. empty+cap+ready
    for (int i = 0; i < 24; i++)
      cycle(1'b1 & (i % 2 == 0), 16'(16'h0100 + i), (i % 3) != 0);
    drain();
    check_state();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
